sprite_rom_arbiter: RTL and testbench
=====================================

Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite ROM (e.g. gemROM, 456 x 8) between up to NUM_REQ sprite units: gems, doors, player overlays.
- Each cycle, grants at most one requester and drives its address to the ROM.
- Returns ROM data tagged with the requester id after ROM_LAT cycles.
- Sits between the per-object sprite units and the single shared ROM instance inside the scene/score controllers. Removes the "no overlapping sprites" restriction on ROM sharing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 9, ROM address width.
- DATA_W, 8, ROM data width.
- ROM_DEPTH, 456, valid ROM words; addresses >= ROM_DEPTH are errors.
- ROM_LAT, 1, ROM read latency in cycles (1..3).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester read request, level, one bit each.
- req_addr  in  NUM_REQ x ADDR_W  per-requester address, valid while req[i]=1.
- fixed_pri  in  1  1 = fixed priority (lowest index wins); 0 = round-robin.
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req.
- rom_addr  out  ADDR_W  address to shared ROM.
- rom_data  in  DATA_W  ROM output, valid ROM_LAT cycles after rom_addr.
- rsp_valid  out  1  response valid.
- rsp_id  out  3  index of requester owning rsp_data.
- rsp_data  out  DATA_W  returned ROM word; 0 when rsp_valid=0.
- conflict_cnt  out  8  saturating count of cycles with >=2 requests.
- addr_err  out  1  sticky: a granted address was >= ROM_DEPTH.
- arb_hex  out  4  debug: {addr_err, rsp_id}.

Behaviour:
- Reset (Reset_n=0, async):
  - rr_ptr=0, tag pipeline cleared, rsp_valid=0, rsp_id=0, conflict_cnt=0, addr_err=0.
  - gnt is forced to 0 while Reset_n=0.
  - Asserting reset mid-operation drops in-flight responses; nothing is replayed.
- Grant, cycle t, combinational:
  - If fixed_pri=1: lowest-index asserted req wins.
  - If fixed_pri=0: first asserted req searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - No req asserted: gnt=0 and rom_addr=0.
- rom_addr:
  - Equals req_addr of the granted requester.
  - If that address is >= ROM_DEPTH, rom_addr=0 instead, and addr_err is set at the next edge and stays set until reset.
- rr_ptr update at edge t:
  - On any grant to i: rr_ptr <= (i+1) mod NUM_REQ. Wrap from NUM_REQ-1 to 0 is required.
  - No grant: rr_ptr holds.
  - rr_ptr also updates in fixed_pri mode, so switching mode mid-stream is glitch-free and needs no reset.
- Tag pipeline:
  - ROM_LAT stages of {valid, id}, stage 0 loaded at edge t with {|gnt, granted id}.
  - At cycle t+ROM_LAT: rsp_valid=1, rsp_id=id, rsp_data=rom_data.
  - Latency is exactly ROM_LAT cycles from grant, with no bubbles. A grant every cycle yields a response every cycle.
- Ungranted requesters:
  - Must hold req and req_addr; the arbiter keeps no request queue.
  - A requester that drops req before being granted is simply never served.
- conflict_cnt increments at an edge when popcount(req) >= 2, saturating at 255. It does not wrap.
- Simultaneous events:
  - A new grant and an outgoing response in the same cycle are independent.
  - Addr-error setting and a grant in the same cycle: the grant proceeds normally, with rom_addr=0 for the erroneous address.
- NUM_REQ=1: gnt=req; rr_ptr stays 0.

Decomposition:
- Package sprite_pkg:
  - localparams SPRITE_ADDR_W=9, SPRITE_DATA_W=8, GEM_ROM_DEPTH=456, MAX_REQ=8.
  - typedef req_id_t (logic [2:0]).
  - typedef tag_t (struct {valid, req_id_t id}).
- Sub-module rr_picker: combinational rotate-priority-rotate-back one-hot picker, with inputs req, ptr, fixed_pri and output gnt. It is the only place the priority search lives, and is reusable for the door/lever arbiters.

Test Plan:
- Single request: req=0001, req_addr[0]=9'd37, ROM_LAT=1 -> gnt=0001 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=mem[37].
- Round-robin: req=1111 held 8 cycles, fixed_pri=0 -> gnt sequence 0001,0010,0100,1000,0001,...; rsp_id sequence 0,1,2,3,0,... one cycle later; conflict_cnt=8.
- Fixed priority: req=0110 held 3 cycles, fixed_pri=1 -> gnt=0010 every cycle; rsp_id=1 each response; then set fixed_pri=0 -> next grant goes to requester 2 (rr_ptr=2).
- Bad address: req=0100, req_addr[2]=9'd500 -> rom_addr=0, addr_err=1 from next cycle, held after req drops; cleared only by Reset_n=0.
- Reset mid-flight: ROM_LAT=3, grants on 3 consecutive cycles, then Reset_n=0 for 1 cycle -> rsp_valid stays 0 for the remaining cycles; after release, rr_ptr=0 and req=1111 grants requester 0 first.
- Saturation: req=0011 held 300 cycles -> conflict_cnt stops at 255 and does not wrap.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite ROM arbiter and the picker it is built on.
// Defaults match the gem ROM (456 x 8) used by the scene and score controllers.
package sprite_pkg;

  localparam int SPRITE_ADDR_W = 9;
  localparam int SPRITE_DATA_W = 8;
  localparam int GEM_ROM_DEPTH = 456;
  localparam int MAX_REQ       = 8;

  typedef logic [2:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  // Round-robin successor of a granted id, wrapping from n-1 back to 0.
  function automatic req_id_t next_ptr(input req_id_t id, input int n);
    if (int'(id) >= n - 1)
      return '0;
    return req_id_t'(id + 3'd1);
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_picker.sv
// One-hot priority picker: rotate the request vector so ptr sits at bit 0, isolate the lowest set bit,
// then rotate back. Fixed-priority mode simply uses a rotation of zero.
module rr_picker
  import sprite_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  req_id_t      ptr,
  input  logic         fixed_pri,
  output logic [N-1:0] gnt
);

  req_id_t        shift;
  logic [2*N-1:0] doubled;
  logic [2*N-1:0] back;
  logic [N-1:0]   rotated;
  logic [N-1:0]   lowest;

  always_comb begin
    shift   = fixed_pri ? '0 : ptr;
    doubled = {req, req} >> shift;
    rotated = doubled[N-1:0];
    // Two's-complement trick keeps only the least significant set bit.
    lowest  = rotated & (-rotated);
    back    = {lowest, lowest} << shift;
    gnt     = back[2*N-1:N];
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM between NUM_REQ sprite units, granting one per cycle and
// returning each ROM word tagged with its owner exactly ROM_LAT cycles after the grant.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = SPRITE_ADDR_W,
  parameter int DATA_W    = SPRITE_DATA_W,
  parameter int ROM_DEPTH = GEM_ROM_DEPTH,
  parameter int ROM_LAT   = 1
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic                           fixed_pri,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [ADDR_W-1:0]              rom_addr,
  input  logic [DATA_W-1:0]              rom_data,
  output logic                           rsp_valid,
  output req_id_t                        rsp_id,
  output logic [DATA_W-1:0]              rsp_data,
  output logic [7:0]                     conflict_cnt,
  output logic                           addr_err,
  output logic [3:0]                     arb_hex
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(ROM_DEPTH);

  req_id_t            rr_ptr;
  req_id_t            gnt_id;
  logic [NUM_REQ-1:0] pick;
  logic [ADDR_W-1:0]  sel_addr;
  logic               sel_bad;
  logic [3:0]         req_cnt;
  tag_t               next_tag;
  tag_t               pipe [ROM_LAT];

  rr_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .req       (req),
    .ptr       (rr_ptr),
    .fixed_pri (fixed_pri),
    .gnt       (pick)
  );

  // Grant is suppressed during reset; an out-of-range address is replaced by 0 so the ROM never sees it.
  always_comb begin
    gnt      = Reset_n ? pick : '0;
    gnt_id   = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_id   = req_id_t'(i);
        sel_addr = req_addr[i];
      end
    end
    sel_bad  = (|gnt) && ({1'b0, sel_addr} >= DEPTH_LIM);
    rom_addr = sel_bad ? '0 : sel_addr;
    req_cnt  = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_cnt = req_cnt + 4'(req[i]);
    next_tag = '{valid: |gnt, id: gnt_id};
  end

  // rr_ptr follows grants in both modes so switching to round-robin needs no resync.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr       <= '0;
      conflict_cnt <= '0;
      addr_err     <= 1'b0;
      for (int s = 0; s < ROM_LAT; s++)
        pipe[s] <= '0;
    end else begin
      if (|gnt)
        rr_ptr <= next_ptr(gnt_id, NUM_REQ);
      pipe[0] <= next_tag;
      for (int s = 1; s < ROM_LAT; s++)
        pipe[s] <= pipe[s-1];
      if ((req_cnt >= 4'd2) && (conflict_cnt != 8'hFF))
        conflict_cnt <= conflict_cnt + 8'd1;
      if (sel_bad)
        addr_err <= 1'b1;
    end
  end

  assign rsp_valid = pipe[ROM_LAT-1].valid;
  assign rsp_id    = pipe[ROM_LAT-1].id;
  assign rsp_data  = rsp_valid ? rom_data : '0;
  assign arb_hex   = {addr_err, rsp_id};

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: one instance with ROM_LAT=1 and one with ROM_LAT=3,
// each backed by its own behavioural ROM whose word at address a is (a*7+3) mod 256.
module tb_sprite_rom_arbiter;
  import sprite_pkg::*;

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic [3:0]      req;
  logic [3:0][8:0] req_addr;
  logic            fixed_pri;

  logic [3:0] gnt_1, gnt_3;
  logic [8:0] rom_addr_1, rom_addr_3;
  logic [7:0] rom_q1, rom_a3, rom_b3, rom_q3;
  logic       rsp_valid_1, rsp_valid_3;
  logic [2:0] rsp_id_1, rsp_id_3;
  logic [7:0] rsp_data_1, rsp_data_3;
  logic [7:0] conflict_cnt_1, conflict_cnt_3;
  logic       addr_err_1, addr_err_3;
  logic [3:0] arb_hex_1, arb_hex_3;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  sprite_rom_arbiter #(.NUM_REQ(4), .ROM_LAT(1)) dut1 (
    .Clk (Clk), .Reset_n (Reset_n), .req (req), .req_addr (req_addr), .fixed_pri (fixed_pri),
    .gnt (gnt_1), .rom_addr (rom_addr_1), .rom_data (rom_q1), .rsp_valid (rsp_valid_1),
    .rsp_id (rsp_id_1), .rsp_data (rsp_data_1), .conflict_cnt (conflict_cnt_1),
    .addr_err (addr_err_1), .arb_hex (arb_hex_1)
  );

  sprite_rom_arbiter #(.NUM_REQ(4), .ROM_LAT(3)) dut3 (
    .Clk (Clk), .Reset_n (Reset_n), .req (req), .req_addr (req_addr), .fixed_pri (fixed_pri),
    .gnt (gnt_3), .rom_addr (rom_addr_3), .rom_data (rom_q3), .rsp_valid (rsp_valid_3),
    .rsp_id (rsp_id_3), .rsp_data (rsp_data_3), .conflict_cnt (conflict_cnt_3),
    .addr_err (addr_err_3), .arb_hex (arb_hex_3)
  );

  function automatic logic [7:0] rom_word(input logic [8:0] a);
    return 8'((int'(a) * 7) + 3);
  endfunction

  always @(posedge Clk) begin
    rom_q1 <= rom_word(rom_addr_1);
    rom_a3 <= rom_word(rom_addr_3);
    rom_b3 <= rom_a3;
    rom_q3 <= rom_b3;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic fp);
    req       = r;
    fixed_pri = fp;
    #1;
  endtask

  initial begin
    Reset_n   = 1'b0;
    req       = 4'hF;
    fixed_pri = 1'b0;
    req_addr  = '0;
    #2;
    checkOutput("reset_gnt1", gnt_1, 4'h0);
    checkOutput("reset_gnt3", gnt_3, 4'h0);
    checkOutput("reset_rsp_valid", rsp_valid_1, 1'b0);
    checkOutput("reset_arb_hex", arb_hex_1, 4'h0);
    req = 4'h0;
    @(posedge Clk);
    #3 Reset_n = 1'b1;
    tick();
    checkOutput("reset_conflict", conflict_cnt_1, 8'd0);

    // Single request, one-cycle ROM
    req_addr[0] = 9'd37;
    applyStimulus(4'b0001, 1'b0);
    checkOutput("single_gnt", gnt_1, 4'b0001);
    checkOutput("single_rom_addr", rom_addr_1, 9'd37);
    tick();
    checkOutput("single_rsp_valid", rsp_valid_1, 1'b1);
    checkOutput("single_rsp_id", rsp_id_1, 3'd0);
    checkOutput("single_rsp_data", rsp_data_1, rom_word(9'd37));

    // Lone request from the top index brings rr_ptr back round to 0
    req_addr[3] = 9'd100;
    applyStimulus(4'b1000, 1'b0);
    checkOutput("top_gnt", gnt_1, 4'b1000);
    tick();
    checkOutput("top_rsp_id", rsp_id_1, 3'd3);
    checkOutput("top_rsp_data", rsp_data_1, rom_word(9'd100));

    // Round-robin over all four requesters
    req_addr = {9'd40, 9'd30, 9'd20, 9'd10};
    applyStimulus(4'b1111, 1'b0);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("rr_gnt_%0d", k), gnt_1, 32'(1 << (k % 4)));
      checkOutput($sformatf("rr_addr_%0d", k), rom_addr_1, 32'(10 * ((k % 4) + 1)));
      if (k > 0)
        checkOutput($sformatf("rr_rsp_id_%0d", k), rsp_id_1, 32'((k - 1) % 4));
      tick();
    end
    checkOutput("rr_last_id", rsp_id_1, 3'd3);
    checkOutput("rr_last_data", rsp_data_1, rom_word(9'd40));
    checkOutput("rr_conflict", conflict_cnt_1, 8'd8);

    // Fixed priority, then back to round-robin resumes after the last winner
    req_addr[1] = 9'd11;
    req_addr[2] = 9'd22;
    applyStimulus(4'b0110, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("fix_gnt_%0d", k), gnt_1, 4'b0010);
      if (k > 0)
        checkOutput($sformatf("fix_rsp_id_%0d", k), rsp_id_1, 3'd1);
      tick();
    end
    checkOutput("fix_rsp_id_last", rsp_id_1, 3'd1);
    applyStimulus(4'b0110, 1'b0);
    checkOutput("switch_gnt1", gnt_1, 4'b0100);
    checkOutput("switch_gnt3", gnt_3, 4'b0100);
    tick();
    checkOutput("switch_rsp_id", rsp_id_1, 3'd2);
    checkOutput("switch_rsp_data", rsp_data_1, rom_word(9'd22));
    checkOutput("switch_conflict", conflict_cnt_1, 8'd12);

    // Out-of-range address
    req_addr[2] = 9'd500;
    applyStimulus(4'b0100, 1'b0);
    checkOutput("bad_gnt", gnt_1, 4'b0100);
    checkOutput("bad_rom_addr", rom_addr_1, 9'd0);
    checkOutput("bad_err_before", addr_err_1, 1'b0);
    tick();
    checkOutput("bad_err_set", addr_err_1, 1'b1);
    checkOutput("bad_arb_hex", arb_hex_1, 4'hA);
    checkOutput("bad_rsp_data", rsp_data_1, rom_word(9'd0));
    applyStimulus(4'b0000, 1'b0);
    tick();
    tick();
    checkOutput("bad_err_sticky", addr_err_1, 1'b1);
    checkOutput("idle_rsp_valid", rsp_valid_1, 1'b0);
    checkOutput("idle_rsp_data", rsp_data_1, 8'd0);
    checkOutput("idle_gnt", gnt_1, 4'b0000);
    checkOutput("idle_rom_addr", rom_addr_1, 9'd0);

    // Short reset clears sticky error and counters
    Reset_n = 1'b0;
    #1;
    checkOutput("rst_err1", addr_err_1, 1'b0);
    checkOutput("rst_err3", addr_err_3, 1'b0);
    checkOutput("rst_conflict", conflict_cnt_1, 8'd0);
    #1 Reset_n = 1'b1;
    tick();

    // Three back-to-back grants into the three-cycle ROM, then reset mid-flight
    req_addr = {9'd40, 9'd30, 9'd20, 9'd10};
    applyStimulus(4'b1111, 1'b0);
    checkOutput("lat3_gnt0", gnt_3, 4'b0001);
    tick();
    checkOutput("lat3_gnt1", gnt_3, 4'b0010);
    checkOutput("lat3_early_valid", rsp_valid_3, 1'b0);
    tick();
    checkOutput("lat3_gnt2", gnt_3, 4'b0100);
    tick();
    checkOutput("lat3_rsp_valid", rsp_valid_3, 1'b1);
    checkOutput("lat3_rsp_id", rsp_id_3, 3'd0);
    checkOutput("lat3_rsp_data", rsp_data_3, rom_word(9'd10));
    req     = 4'b0000;
    Reset_n = 1'b0;
    #1;
    checkOutput("flight_drop_now", rsp_valid_3, 1'b0);
    tick();
    checkOutput("flight_drop_hold", rsp_valid_3, 1'b0);
    Reset_n = 1'b1;
    tick();
    checkOutput("flight_drop_a", rsp_valid_3, 1'b0);
    tick();
    checkOutput("flight_drop_b", rsp_valid_3, 1'b0);

    // After release rr_ptr is 0; then hold two requests long enough to saturate the counter
    applyStimulus(4'b0011, 1'b0);
    checkOutput("post_rst_gnt3", gnt_3, 4'b0001);
    checkOutput("post_rst_gnt1", gnt_1, 4'b0001);
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 254)
        checkOutput("sat_254", conflict_cnt_1, 8'd254);
      if (k == 255)
        checkOutput("sat_255", conflict_cnt_1, 8'd255);
    end
    checkOutput("sat_hold1", conflict_cnt_1, 8'd255);
    checkOutput("sat_hold3", conflict_cnt_3, 8'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
